// File: rtl/result_checker_if.sv
// Bundle of the model/DUT item streams, the flush control and the
// comparison/status results of the result checker.
interface result_checker_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              clear;

    logic              model_valid;
    logic              model_ready;
    logic [DATA_W-1:0] model_data;
    logic [ADDR_W-1:0] model_addr;
    logic              model_dir;

    logic              dut_valid;
    logic              dut_ready;
    logic [DATA_W-1:0] dut_data;
    logic [ADDR_W-1:0] dut_addr;
    logic              dut_dir;

    logic              cmp_valid;
    logic [2:0]        cmp_err;
    logic [CNT_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  error_cnt;
    logic              timeout;
    logic [LVL_W-1:0]  model_level;
    logic [LVL_W-1:0]  dut_level;

    // Environment side: supplies items and flush, observes results
    modport master (
        output clear,
        output model_valid, model_data, model_addr, model_dir,
        output dut_valid, dut_data, dut_addr, dut_dir,
        input  model_ready, dut_ready,
        input  cmp_valid, cmp_err, match_cnt, error_cnt, timeout,
        input  model_level, dut_level
    );

    // Checker side: accepts items and flush, drives results
    modport slave (
        input  clear,
        input  model_valid, model_data, model_addr, model_dir,
        input  dut_valid, dut_data, dut_addr, dut_dir,
        output model_ready, dut_ready,
        output cmp_valid, cmp_err, match_cnt, error_cnt, timeout,
        output model_level, dut_level
    );
endinterface

// File: rtl/result_checker.sv
// In-order model-vs-DUT transaction comparator: two item FIFOs, a registered
// per-pair error field, saturating match/error counters and a one-sided
// stall detector that latches a sticky timeout flag.
module result_checker #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    result_checker_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [PTR_W-1:0] FULL_LVL = PTR_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              dir;
    } item_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        TOUT = 2'd2
    } state_t;

    item_t            modelMem_q [DEPTH];
    item_t            dutMem_q   [DEPTH];
    logic [PTR_W-1:0] mWr_q, mRd_q, dWr_q, dRd_q;
    logic [PTR_W-1:0] mWr_d, mRd_d, dWr_d, dRd_d;
    logic [CNT_W-1:0] matchCnt_q, errorCnt_q, matchCnt_d, errorCnt_d;
    logic             cmpValid_q, cmpValid_d;
    logic [2:0]       cmpErr_q, cmpErr_d;
    state_t           state_q;
    logic [TMR_W-1:0] timer_q;
    logic             timeout_q;

    logic [PTR_W-1:0] mLevel, dLevel;
    logic             mEmpty, dEmpty, mFull, dFull;
    logic             mPush, dPush, pop, oneSide;
    item_t            mHead, dHead;
    logic [2:0]       errNow;

    // Occupancy and handshake are derived from registered pointers only,
    // so a pop in the same cycle never frees a slot for a push.
    always_comb begin
        mLevel  = mWr_q - mRd_q;
        dLevel  = dWr_q - dRd_q;
        mEmpty  = (mLevel == '0);
        dEmpty  = (dLevel == '0);
        mFull   = (mLevel == FULL_LVL);
        dFull   = (dLevel == FULL_LVL);
        mPush   = bus.model_valid && !mFull && !bus.clear;
        dPush   = bus.dut_valid && !dFull && !bus.clear;
        pop     = !mEmpty && !dEmpty && !bus.clear;
        oneSide = mEmpty != dEmpty;
        mHead   = modelMem_q[mRd_q[IDX_W-1:0]];
        dHead   = dutMem_q[dRd_q[IDX_W-1:0]];
        errNow  = {mHead.dir != dHead.dir,
                   mHead.addr != dHead.addr,
                   mHead.data != dHead.data};
    end

    // Next-state for pointers, compare result and saturating counters;
    // clear wins over every push, pop and counter update.
    always_comb begin
        mWr_d      = mWr_q;
        mRd_d      = mRd_q;
        dWr_d      = dWr_q;
        dRd_d      = dRd_q;
        matchCnt_d = matchCnt_q;
        errorCnt_d = errorCnt_q;
        cmpValid_d = 1'b0;
        cmpErr_d   = 3'b000;
        if (bus.clear) begin
            mWr_d      = '0;
            mRd_d      = '0;
            dWr_d      = '0;
            dRd_d      = '0;
            matchCnt_d = '0;
            errorCnt_d = '0;
        end else begin
            if (mPush) mWr_d = mWr_q + 1'b1;
            if (dPush) dWr_d = dWr_q + 1'b1;
            if (pop) begin
                mRd_d      = mRd_q + 1'b1;
                dRd_d      = dRd_q + 1'b1;
                cmpValid_d = 1'b1;
                cmpErr_d   = errNow;
                if (errNow == 3'b000) begin
                    if (matchCnt_q != '1) matchCnt_d = matchCnt_q + 1'b1;
                end else begin
                    if (errorCnt_q != '1) errorCnt_d = errorCnt_q + 1'b1;
                end
            end
        end
    end

    // Item storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (mPush) modelMem_q[mWr_q[IDX_W-1:0]] <= {bus.model_data, bus.model_addr, bus.model_dir};
        if (dPush) dutMem_q[dWr_q[IDX_W-1:0]]   <= {bus.dut_data, bus.dut_addr, bus.dut_dir};
    end

    // Pointer, result and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mWr_q      <= '0;
            mRd_q      <= '0;
            dWr_q      <= '0;
            dRd_q      <= '0;
            matchCnt_q <= '0;
            errorCnt_q <= '0;
            cmpValid_q <= 1'b0;
            cmpErr_q   <= 3'b000;
        end else begin
            mWr_q      <= mWr_d;
            mRd_q      <= mRd_d;
            dWr_q      <= dWr_d;
            dRd_q      <= dRd_d;
            matchCnt_q <= matchCnt_d;
            errorCnt_q <= errorCnt_d;
            cmpValid_q <= cmpValid_d;
            cmpErr_q   <= cmpErr_d;
        end
    end

    // Stall detector: times how long exactly one side stays non-empty and
    // latches timeout once that reaches TIMEOUT cycles in PEND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else if (bus.clear) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (oneSide) begin
                        state_q <= PEND;
                        timer_q <= '0;
                    end
                end
                PEND: begin
                    if (!oneSide) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                    end else if (timer_q == TMR_LAST) begin
                        state_q   <= TOUT;
                        timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                TOUT: begin
                    timeout_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign bus.model_ready = !mFull;
    assign bus.dut_ready   = !dFull;
    assign bus.model_level = mLevel;
    assign bus.dut_level   = dLevel;
    assign bus.cmp_valid   = cmpValid_q;
    assign bus.cmp_err     = cmpErr_q;
    assign bus.match_cnt   = matchCnt_q;
    assign bus.error_cnt   = errorCnt_q;
    assign bus.timeout     = timeout_q;
endmodule
